// File: rtl/spectro_capture_engine.sv
// Spectrogram capture engine: per-channel/band edge counters over RTC slots, threshold-triggered
// frame capture and multi-lane serial readout. Define SPECTRO_PRETRIG_EN to keep one pre-trigger slot.
module spectro_capture_engine #(
  parameter int N_CH      = 2,
  parameter int CH_BITS   = 7,
  parameter int CNT_W     = 4,
  parameter int N_SLOTS   = 8,
  parameter int SER_LANES = 2,
  parameter int THRESH    = 3
) (
  input  logic                    input_acquisition_clk,
  input  logic                    reset,
  input  logic                    rtc_clk_in,
  input  logic                    readout_clk_in,
  input  logic [N_CH*CH_BITS-1:0] ch,
  output logic [SER_LANES-1:0]    serial_out,
  output logic                    sl_time,
  output logic                    sl_ch,
  output logic                    signal_detected,
  output logic                    memorization_completed,
  output logic                    serial_readout,
  output logic                    sending_data
);

  localparam int N_BINS = N_CH * CH_BITS;
  localparam int SPB    = CNT_W / SER_LANES;
  localparam int SYNC_W = N_BINS + 2;
  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CHI_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BAND_W = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
  localparam int BIN_W  = (N_BINS > 1) ? $clog2(N_BINS) : 1;
  localparam int SUB_W  = (SPB > 1) ? $clog2(SPB) : 1;
`ifdef SPECTRO_PRETRIG_EN
  localparam int FIRST_IDX = 2;
`else
  localparam int FIRST_IDX = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE,
    S_SEND
  } state_t;

  state_t state, state_next;

  logic [SYNC_W-1:0] sync1, sync2, sync_prev, rise;
  logic [N_BINS-1:0] band_edge;
  logic              slot_tick, rd_tick;

  logic [CNT_W-1:0]  cnt [N_BINS];
  logic [CNT_W-1:0]  mem [N_SLOTS][N_BINS];
  logic              hit;

  logic [SLOT_W-1:0] idx;
  logic [SLOT_W-1:0] rd_slot;
  logic [CHI_W-1:0]  rd_ch;
  logic [BAND_W-1:0] rd_band;
  logic [SUB_W-1:0]  rd_sub;
  logic [BIN_W-1:0]  rd_bin;
  logic [CNT_W-1:0]  cur_word, shifted;

  logic det_store, cap_store, start_send, step_sym, last_slot, last_sym;

  // Pins are asynchronous to the acquisition clock: two flops, then a previous-value stage for edges.
  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= {readout_clk_in, rtc_clk_in, ch};
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise      = sync2 & ~sync_prev;
  assign band_edge = rise[N_BINS-1:0];
  assign slot_tick = rise[N_BINS];
  assign rd_tick   = rise[N_BINS+1];

  // An edge coinciding with the slot boundary belongs to the new slot.
  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < N_BINS; b++) cnt[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < N_BINS; b++) begin
        if (slot_tick)
          cnt[b] <= CNT_W'(band_edge[b]);
        else if (band_edge[b] && (cnt[b] != '1))
          cnt[b] <= cnt[b] + 1'b1;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned b = 0; b < N_BINS; b++) begin
      if (cnt[b] >= CNT_W'(THRESH)) hit = 1'b1;
    end
  end

`ifdef SPECTRO_PRETRIG_EN
  logic [CNT_W-1:0] shadow [N_BINS];

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < N_BINS; b++) shadow[b] <= '0;
    end else if (slot_tick) begin
      for (int unsigned b = 0; b < N_BINS; b++) shadow[b] <= cnt[b];
    end
  end
`endif

  assign last_slot = (idx == SLOT_W'(N_SLOTS - 1));
  assign last_sym  = (rd_slot == SLOT_W'(N_SLOTS - 1)) && (rd_ch == CHI_W'(N_CH - 1)) &&
                     (rd_band == BAND_W'(CH_BITS - 1)) && (rd_sub == SUB_W'(SPB - 1));

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    det_store  = 1'b0;
    cap_store  = 1'b0;
    start_send = 1'b0;
    step_sym   = 1'b0;
    case (state)
      S_IDLE: begin
        if (slot_tick && hit) begin
          det_store  = 1'b1;
          state_next = (FIRST_IDX >= N_SLOTS) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (slot_tick) begin
          cap_store = 1'b1;
          if (last_slot) state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (rd_tick) begin
          start_send = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (rd_tick) begin
          step_sym = 1'b1;
          if (last_sym) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      idx <= '0;
    end else if (state_next == S_IDLE) begin
      idx <= '0;
    end else if (det_store) begin
      idx <= SLOT_W'(FIRST_IDX);
    end else if (cap_store) begin
      idx <= idx + 1'b1;
    end
  end

  // Frame memory carries no reset; its contents are only observable in SEND.
  always_ff @(posedge input_acquisition_clk) begin
    if (det_store) begin
`ifdef SPECTRO_PRETRIG_EN
      for (int unsigned b = 0; b < N_BINS; b++) begin
        mem[0][b] <= shadow[b];
        mem[1][b] <= cnt[b];
      end
`else
      for (int unsigned b = 0; b < N_BINS; b++) mem[0][b] <= cnt[b];
`endif
    end else if (cap_store) begin
      for (int unsigned b = 0; b < N_BINS; b++) mem[idx][b] <= cnt[b];
    end
  end

  // Readout position as nested slot/channel/band/sub-symbol counters, innermost first.
  always_ff @(posedge input_acquisition_clk) begin
    if (reset || start_send) begin
      rd_slot <= '0;
      rd_ch   <= '0;
      rd_band <= '0;
      rd_sub  <= '0;
    end else if (step_sym) begin
      if (rd_sub != SUB_W'(SPB - 1)) begin
        rd_sub <= rd_sub + 1'b1;
      end else begin
        rd_sub <= '0;
        if (rd_band != BAND_W'(CH_BITS - 1)) begin
          rd_band <= rd_band + 1'b1;
        end else begin
          rd_band <= '0;
          if (rd_ch != CHI_W'(N_CH - 1)) begin
            rd_ch <= rd_ch + 1'b1;
          end else begin
            rd_ch   <= '0;
            rd_slot <= (rd_slot == SLOT_W'(N_SLOTS - 1)) ? '0 : rd_slot + 1'b1;
          end
        end
      end
    end
  end

  assign rd_bin = BIN_W'(rd_ch) * BIN_W'(CH_BITS) + BIN_W'(rd_band);

  always_comb begin
    serial_out = '0;
    sl_time    = 1'b0;
    sl_ch      = 1'b0;
    cur_word   = mem[rd_slot][rd_bin];
    shifted    = cur_word << (int'(rd_sub) * SER_LANES);
    if (state == S_SEND) begin
      serial_out = shifted[CNT_W-1 -: SER_LANES];
      sl_ch      = (rd_band == '0) && (rd_sub == '0);
      sl_time    = (rd_band == '0) && (rd_sub == '0) && (rd_ch == '0);
    end
  end

  assign signal_detected        = (state != S_IDLE);
  assign memorization_completed = (state == S_DONE) || (state == S_SEND);
  assign serial_readout         = (state == S_DONE) || (state == S_SEND);
  assign sending_data           = (state == S_SEND);

endmodule

// File: tb/tb_spectro_capture_engine.sv
// Scoreboard bench for spectro_capture_engine (default parameters); also covers SPECTRO_PRETRIG_EN builds.
module tb_spectro_capture_engine;

`ifdef SPECTRO_PRETRIG_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rtc;
  logic        rdclk;
  logic [13:0] ch;
  logic [1:0]  serial_out;
  logic        sl_time, sl_ch, signal_detected, memorization_completed, serial_readout, sending_data;

  always #5 clk = ~clk;

  spectro_capture_engine #(
    .N_CH(2), .CH_BITS(7), .CNT_W(4), .N_SLOTS(8), .SER_LANES(2), .THRESH(3)
  ) dut (
    .input_acquisition_clk (clk),
    .reset                 (reset),
    .rtc_clk_in            (rtc),
    .readout_clk_in        (rdclk),
    .ch                    (ch),
    .serial_out            (serial_out),
    .sl_time               (sl_time),
    .sl_ch                 (sl_ch),
    .signal_detected       (signal_detected),
    .memorization_completed(memorization_completed),
    .serial_readout        (serial_readout),
    .sending_data          (sending_data)
  );

  typedef struct packed {
    logic [1:0] so;
    logic       t;
    logic       c;
    logic       sd;
  } sym_t;

  sym_t       exp_q[$];
  int         tag_q[$];
  logic [3:0] exp_mem [8][14];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int all_outs();
    return int'({serial_out, sl_time, sl_ch, signal_detected,
                 memorization_completed, serial_readout, sending_data});
  endfunction

  // Expected symbol k: slot-major, then channel, then band, MSB pair first.
  function automatic sym_t exp_sym(input int k);
    sym_t       r;
    logic [3:0] w;
    w    = exp_mem[k / 28][(k / 2) % 14];
    r.so = ((k % 2) == 0) ? w[3:2] : w[1:0];
    r.t  = ((k % 28) == 0);
    r.c  = ((k % 14) == 0);
    r.sd = 1'b1;
    return r;
  endfunction

  task automatic clear_exp();
    for (int s = 0; s < 8; s++)
      for (int b = 0; b < 14; b++) exp_mem[s][b] = 4'd0;
  endtask

  task automatic push_exp(input sym_t e, input int tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic band_pulse(input int bit_i, input int n);
    for (int i = 0; i < n; i++) begin
      ch[bit_i] = 1'b1;
      cyc(2);
      ch[bit_i] = 1'b0;
      cyc(2);
    end
  endtask

  task automatic slot_tick();
    rtc = 1'b1;
    cyc(3);
    rtc = 1'b0;
    cyc(5);
  endtask

  task automatic coincident_tick(input int bit_i);
    ch[bit_i] = 1'b1;
    rtc       = 1'b1;
    cyc(3);
    rtc = 1'b0;
    cyc(1);
    ch[bit_i] = 1'b0;
    cyc(4);
  endtask

  task automatic rd_edge(input sym_t e, input int tag);
    push_exp(e, tag);
    rdclk = 1'b1;
    cyc(5);
    rdclk = 1'b0;
    cyc(5);
  endtask

  task automatic run_readout(input int n_edges);
    for (int i = 0; i < n_edges; i++) begin
      if (i < 224) rd_edge(exp_sym(i), i);
      else         rd_edge('0, i);
    end
  endtask

  // Monitor: each readout edge settles, then the presented symbol is compared with the queue head.
  initial begin
    sym_t e;
    int   tag;
    forever begin
      @(posedge rdclk);
      repeat (7) @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        chk($sformatf("sym%0d", tag), int'({serial_out, sl_time, sl_ch, sending_data}), int'(e));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rtc   = 1'b0;
    rdclk = 1'b0;
    ch    = '0;
    push_exp('0, -1);
    repeat (2) begin
      @(negedge clk);
      rtc   = ~rtc;
      rdclk = ~rdclk;
    end
    cyc(1);
    chk("reset_outs", all_outs(), 0);
    reset = 1'b0;
    cyc(8);
    chk("post_reset_outs", all_outs(), 0);

    for (int s = 0; s < 5; s++) begin
      band_pulse(0, 2);
      slot_tick();
      chk("below_det", int'(signal_detected), 0);
      chk("below_ro", int'(serial_readout), 0);
    end

    // Frame 1: ch0 band3 gets 3+k pulses in slot k, ch1 band6 one pulse.
    clear_exp();
    if (PRE) exp_mem[0][0] = 4'd2;
    for (int k = 0; k < 8; k++) begin
      band_pulse(3, 3 + k);
      band_pulse(13, 1);
      if (k + int'(PRE) < 8) begin
        exp_mem[k + int'(PRE)][3]  = 4'(3 + k);
        exp_mem[k + int'(PRE)][13] = 4'd1;
      end
      slot_tick();
      if (k == 0) chk("det_flag", int'(signal_detected), 1);
      if (k == 6) chk("mc_before_last", int'(memorization_completed), int'(PRE));
    end
    chk("mc_done", int'(memorization_completed), 1);
    chk("ro_done", int'(serial_readout), 1);
    chk("sd_done", int'(sending_data), 0);
    chk("so_done", int'(serial_out), 0);
    run_readout(225);
    chk("idle_after_f1", all_outs(), 0);

    // Frame 2: saturation of a 20-pulse bin and an edge coincident with the detecting tick.
    clear_exp();
    if (PRE) begin
      exp_mem[0][3]  = 4'd10;
      exp_mem[0][13] = 4'd1;
      exp_mem[1][5]  = 4'd15;
      exp_mem[2][0]  = 4'd1;
    end else begin
      exp_mem[0][5] = 4'd15;
      exp_mem[1][0] = 4'd1;
    end
    band_pulse(5, 20);
    coincident_tick(0);
    chk("det_flag_f2", int'(signal_detected), 1);
    for (int k = 0; k < 7; k++) slot_tick();
    chk("mc_f2", int'(memorization_completed), 1);
    run_readout(225);
    chk("idle_after_f2", all_outs(), 0);

    // Frame 3: reset while symbol 50 is on the lines; later readout edges must do nothing.
    clear_exp();
    if (PRE) exp_mem[1][3] = 4'd3;
    else     exp_mem[0][3] = 4'd3;
    band_pulse(3, 3);
    slot_tick();
    for (int k = 0; k < 7; k++) slot_tick();
    chk("mc_f3", int'(memorization_completed), 1);
    run_readout(51);
    chk("send_before_reset", int'(sending_data), 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_reset_outs", all_outs(), 0);
    reset = 1'b0;
    cyc(3);
    for (int i = 0; i < 3; i++) rd_edge('0, 1000 + i);
    chk("ignored_rd_outs", all_outs(), 0);
    cyc(10);
    chk("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spectro_capture_engine.md
Name: spectro_capture_engine

Overview:
- Parametrised successor of the two-channel, 7-band spectrogram extractor core.
- Counts band-activity edges per channel/band over RTC-defined time slots and raises a detection flag when any bin reaches a threshold.
- On detection, memorises a frame of N_SLOTS slots, then serialises it over SER_LANES lanes with time/channel sync markers.
- Runs entirely in the acquisition clock domain. RTC and readout clocks enter as slow inputs and are synchronised and edge-detected internally.

Parameters:
- N_CH, 2, number of input channels.
- CH_BITS, 7, bands per channel (one activity bit each).
- CNT_W, 4, saturating count width per bin.
- N_SLOTS, 8, time slots per memorised frame (≥2).
- SER_LANES, 2, serial output lanes. CNT_W % SER_LANES == 0 is required.
- THRESH, 3, detection threshold; any bin count ≥ THRESH triggers.

Ports:
- input_acquisition_clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- rtc_clk_in, in, 1: slot clock; its rising edge closes the current slot.
- readout_clk_in, in, 1: readout step; its rising edge advances the serializer.
- ch, in, N_CH*CH_BITS: band activity. Channel c, band b is bit c*CH_BITS+b.
- serial_out, out, SER_LANES: data symbol; the lane SER_LANES-1 bit is the more significant.
- sl_time, out, 1: high during the first symbol of each slot.
- sl_ch, out, 1: high during the first symbol of each channel block.
- signal_detected, out, 1: detection latched.
- memorization_completed, out, 1: frame stored, awaiting readout.
- serial_readout, out, 1: frame available or being sent (DONE or SEND).
- sending_data, out, 1: serial_out carries valid data (SEND only).

Behaviour:
- Interface: single clock input_acquisition_clk. reset is synchronous and active-high.
- Input synchronisation:
  - rtc_clk_in, readout_clk_in and every ch bit pass a 2-FF synchronizer plus a previous-value register.
  - slot_tick, rd_tick and band edge pulses are 1-cycle rising-edge strobes. Latency from a pin edge to its strobe is 3 cycles.
- Counting:
  - One CNT_W counter per bin; it increments on a band edge and saturates at 2^CNT_W-1.
  - On slot_tick all counters clear. A band edge coincident with slot_tick loads 1 into the new slot.
  - Counting runs in every state.
- Detection: evaluated only on slot_tick, using the pre-clear counts.
- State machine:
  - IDLE:
    - slot_tick with any bin ≥ THRESH stores the counts as memory slot 0 and sets signal_detected (next cycle).
    - slot index becomes 1; go to CAPTURE.
  - CAPTURE:
    - Each slot_tick stores the counts into memory slot[idx] and increments idx.
    - After slot N_SLOTS-1 is stored: memorization_completed=1, go to DONE.
  - DONE:
    - serial_readout=1. slot_tick is ignored for storage.
    - First rd_tick moves to SEND with symbol 0 presented the following cycle.
  - SEND:
    - sending_data=1. Each rd_tick advances one symbol.
    - rd_tick on the last symbol returns to IDLE. All flags and outputs clear next cycle; memory contents are retained but not visible.
- Serial order:
  - Slot 0..N_SLOTS-1, then channel 0..N_CH-1, then band 0..CH_BITS-1.
  - Within a bin, MSB first, SER_LANES bits per symbol.
  - Total symbols = N_SLOTS*N_CH*CH_BITS*CNT_W/SER_LANES; default is 224.
- sl_time is high on symbol 0 of each slot. sl_ch is high on symbol 0 of each channel block, so it is also high whenever sl_time is high.
- Outputs outside SEND: serial_out=0, sl_time=0, sl_ch=0.
- Reset values: all outputs 0, state IDLE, counters 0, idx 0. Memory contents are don't-care.
- Reset mid-CAPTURE or mid-SEND aborts immediately. The next frame needs a fresh detection.
- rd_tick in IDLE or CAPTURE is ignored.

Optional Feature:
- Macro: SPECTRO_PRETRIG_EN.
- Defined:
  - A shadow register holds the previous slot's counts (cleared by reset).
  - On detection, the shadow goes to memory slot 0 and the detecting slot to slot 1; capture continues from idx=2.
  - If detection occurs on the first slot after reset, slot 0 holds zeros.
- Undefined: no shadow register; behaviour is as above.

Test Plan:
- Reset: assert reset 2 cycles with rtc/readout toggling -> all outputs 0; no detection.
- Below threshold: pulse ch bit 0 twice per slot for 5 slots -> signal_detected stays 0; state stays IDLE.
- Capture frame:
  - Stimulus: slot k uses ch0 band3 with 3+k pulses (saturating at 15) and ch1 band6 with 1 pulse.
  - Detection at slot 0, then 8 slot_ticks -> memorization_completed=1 and serial_readout=1.
- Readout:
  - Issue 225 readout edges.
  - Symbols 6 and 7 (ch0 band3, slot 0) read 2'b00 then 2'b11 (count 3). sl_time is high on symbols 0, 28, 56, …; sl_ch on symbols 0, 14, 28, ….
  - After the 225th edge: all flags 0, state IDLE.
- Simultaneity: band edge on the same cycle as slot_tick -> the new slot's bin reads 1. A counter fed 20 pulses reads 15.
- Mid-operation reset: reset at symbol 50 -> outputs 0 next cycle; readout edges are then ignored until a new detection. With SPECTRO_PRETRIG_EN, slot 0 equals the pre-detection slot counts.
